// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the multi-channel bit-clock generator.
// Optional sync_req input is enabled by defining CLKGEN_SYNC_EN.
package clk_gen_pkg;

  localparam int MIN_DIV   = 2;
  localparam int DEF_DIV_W = 16;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } chan_state_t;

endpackage

// File: rtl/clk_gen_chan.sv
// One divided-clock channel: enable FSM, period counter, shadow/active ratio,
// registered bit clock with coincident edge strobes and sticky ratio error.
module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_ratio,
  input  logic             i_sync,
  output logic             o_bit_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_err
);

  localparam logic [DIV_W-1:0] LP_DEF = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] LP_MIN = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);

  chan_state_t      r_state;
  chan_state_t      w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_shadow;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;
  logic             r_err;

  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_act_nxt;
  logic [DIV_W-1:0] w_sh_nxt;
  logic             w_valid;
  logic             w_wrap;
  logic             w_restart;
  logic             w_err_nxt;
  logic             w_clk_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // High phase length: ceil(a/2) without widening a.
  function automatic logic [DIV_W-1:0] f_half(
    input logic [DIV_W-1:0] a
  );
    return (a >> 1) + {{(DIV_W-1){1'b0}}, a[0]};
  endfunction

  // A load on the wrap edge bypasses the shadow into the next period.
  assign w_valid   = i_ratio >= LP_MIN;
  assign w_sh_nxt  = (i_load && w_valid) ? i_ratio : r_shadow;
  assign w_err_nxt = i_load ? !w_valid : r_err;
  assign w_wrap    = r_cnt == (r_active - LP_ONE);
  assign w_restart = w_wrap || i_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (i_en)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!i_en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt  = '0;
    w_act_nxt  = r_active;
    w_clk_nxt  = 1'b0;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_act_nxt  = w_sh_nxt;
        w_clk_nxt  = i_en;
        w_rise_nxt = i_en;
      end
      ST_RUN: begin
        if (i_en) begin
          if (w_restart) begin
            w_act_nxt = w_sh_nxt;
          end else begin
            w_cnt_nxt = r_cnt + LP_ONE;
          end
          w_clk_nxt  = w_cnt_nxt < f_half(w_act_nxt);
          w_rise_nxt = (w_clk_nxt && !r_clk) || i_sync;
          w_fall_nxt = r_clk && !w_clk_nxt;
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_active <= LP_DEF;
      r_shadow <= LP_DEF;
      r_clk    <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_active <= w_act_nxt;
      r_shadow <= w_sh_nxt;
      r_clk    <= w_clk_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign o_bit_clk = r_clk;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_err     = r_err;

endmodule

// File: rtl/clk_gen_multi.sv
// NCH independent divided bit clocks from sys_clk for FSK bit timing.
// Define CLKGEN_SYNC_EN to add sync_req, which phase-aligns all running channels.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
`ifdef CLKGEN_SYNC_EN
  input  logic                 sync_req,
`endif
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH*DIV_W-1:0] div_ratio,
  input  logic [NCH-1:0]       div_load,
  output logic [NCH-1:0]       bit_clk,
  output logic [NCH-1:0]       rise_tick,
  output logic [NCH-1:0]       fall_tick,
  output logic [NCH-1:0]       div_err
);

  logic w_sync;

`ifdef CLKGEN_SYNC_EN
  assign w_sync = sync_req;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    clk_gen_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .i_clk     (sys_clk),
      .i_rst     (rst),
      .i_en      (ch_en[gi]),
      .i_load    (div_load[gi]),
      .i_ratio   (div_ratio[gi*DIV_W +: DIV_W]),
      .i_sync    (w_sync),
      .o_bit_clk (bit_clk[gi]),
      .o_rise    (rise_tick[gi]),
      .o_fall    (fall_tick[gi]),
      .o_err     (div_err[gi])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Randomised bench for clk_gen_multi with a time-based period model
// and a few hand-computed waveform expectations.
module tb_clk_gen_multi;

  localparam int NCH     = 2;
  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 16;

  logic                 sys_clk = 1'b0;
  logic                 rst;
  logic                 sync_req;
  logic [NCH-1:0]       ch_en;
  logic [NCH*DIV_W-1:0] div_ratio;
  logic [NCH-1:0]       div_load;
  logic [NCH-1:0]       bit_clk;
  logic [NCH-1:0]       rise_tick;
  logic [NCH-1:0]       fall_tick;
  logic [NCH-1:0]       div_err;

  always #5 sys_clk = ~sys_clk;

  clk_gen_multi #(
    .NCH     (NCH),
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
`ifdef CLKGEN_SYNC_EN
    .sync_req  (sync_req),
`endif
    .ch_en     (ch_en),
    .div_ratio (div_ratio),
    .div_load  (div_load),
    .bit_clk   (bit_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .div_err   (div_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int k      = 0;
  logic [31:0] hist;

  // Model: each running channel remembers when its period began and how long it is.
  bit m_run[NCH];
  int m_start[NCH];
  int m_per[NCH];
  int m_sh[NCH];
  bit m_clk[NCH];
  bit m_rise[NCH];
  bit m_fall[NCH];
  bit m_err[NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c]   = 1'b0;
      m_start[c] = 0;
      m_per[c]   = DEF_DIV;
      m_sh[c]    = DEF_DIV;
      m_clk[c]   = 1'b0;
      m_rise[c]  = 1'b0;
      m_fall[c]  = 1'b0;
      m_err[c]   = 1'b0;
    end
  endfunction

  task automatic model_edge(input logic [NCH-1:0] en,
                            input logic [NCH-1:0] ld,
                            input logic [NCH*DIV_W-1:0] rat,
                            input logic sy);
    k++;
    for (int c = 0; c < NCH; c++) begin
      int r;
      int nsh;
      bit nclk;
      r   = int'(rat[c*DIV_W +: DIV_W]);
      nsh = m_sh[c];
      if (ld[c]) begin
        m_err[c] = (r < 2);
        if (r >= 2) begin
          m_sh[c] = r;
          nsh     = r;
        end
      end
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (!m_run[c]) begin
        m_per[c] = nsh;
        m_clk[c] = en[c];
        if (en[c]) begin
          m_run[c]   = 1'b1;
          m_start[c] = k;
          m_rise[c]  = 1'b1;
        end
      end else if (!en[c]) begin
        m_run[c] = 1'b0;
        m_clk[c] = 1'b0;
      end else begin
        if (sy || (k - m_start[c] == m_per[c])) begin
          m_start[c] = k;
          m_per[c]   = nsh;
        end
        nclk      = (k - m_start[c]) < (m_per[c] + 1) / 2;
        m_rise[c] = sy || (nclk && !m_clk[c]);
        m_fall[c] = !nclk && m_clk[c];
        m_clk[c]  = nclk;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h want %h", name, k, act, exp);
  endtask

  function automatic logic [4*NCH-1:0] model_vec();
    logic [NCH-1:0] c_v, r_v, f_v, e_v;
    for (int c = 0; c < NCH; c++) begin
      c_v[c] = m_clk[c];
      r_v[c] = m_rise[c];
      f_v[c] = m_fall[c];
      e_v[c] = m_err[c];
    end
    return {c_v, r_v, f_v, e_v};
  endfunction

  // Drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic step(input logic [NCH-1:0] en, input logic [NCH-1:0] ld,
                      input logic [NCH*DIV_W-1:0] rat, input logic sy);
    ch_en     = en;
    div_load  = ld;
    div_ratio = rat;
    sync_req  = sy;
    model_edge(en, ld, rat, sy);
    @(negedge sys_clk);
    check("cycle", 32'({bit_clk, rise_tick, fall_tick, div_err}),
          32'(model_vec()));
    hist = {hist[30:0], bit_clk[0]};
  endtask

  function automatic logic [NCH*DIV_W-1:0] rr(input int a, input int b);
    return {16'(b), 16'(a)};
  endfunction

  initial begin
    rst       = 1'b1;
    ch_en     = '0;
    div_load  = '0;
    div_ratio = '0;
    sync_req  = 1'b0;
    hist      = '0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    check("reset_state",
          32'({bit_clk, rise_tick, fall_tick, div_err}), 32'h0);

    // Ratio 4: 1100 repeating, first rise one clock after enable.
    step(2'b00, 2'b01, rr(4, 0), 1'b0);
    hist = '0;
    step(2'b01, 2'b00, rr(4, 0), 1'b0);
    check("t1_first_rise", 32'(rise_tick), 32'h1);
    repeat (7) step(2'b01, 2'b00, rr(4, 0), 1'b0);
    check("t1_pattern", hist[7:0], 32'b11001100);

    // Ratio 5: high 3, low 2.
    step(2'b00, 2'b01, rr(5, 0), 1'b0);
    hist = '0;
    repeat (10) step(2'b01, 2'b00, rr(5, 0), 1'b0);
    check("t2_pattern", hist[9:0], 32'b1110011100);

    // Ratio 8, load 4 at cnt=2: current period stays 8.
    step(2'b00, 2'b01, rr(8, 0), 1'b0);
    hist = '0;
    repeat (3) step(2'b01, 2'b00, rr(8, 0), 1'b0);
    step(2'b01, 2'b01, rr(4, 0), 1'b0);
    repeat (12) step(2'b01, 2'b00, rr(4, 0), 1'b0);
    check("t3_8_then_4", hist[15:0], 32'b1111000011001100);
    hist = '0;
    step(2'b01, 2'b01, rr(6, 0), 1'b0);
    repeat (11) step(2'b01, 2'b00, rr(6, 0), 1'b0);
    check("t3_wrap_load6", hist[11:0], 32'b111000111000);

    // Bad ratio sets the sticky error, a good one clears it.
    step(2'b01, 2'b01, rr(1, 0), 1'b0);
    check("t4_err_set", 32'(div_err), 32'h1);
    repeat (7) step(2'b01, 2'b00, rr(0, 0), 1'b0);
    step(2'b01, 2'b01, rr(10, 0), 1'b0);
    check("t4_err_clr", 32'(div_err), 32'h0);
    repeat (24) step(2'b01, 2'b00, rr(0, 0), 1'b0);

    // Disable mid-high: low next clock, no fall strobe.
    step(2'b00, 2'b00, rr(0, 0), 1'b0);
    step(2'b01, 2'b00, rr(0, 0), 1'b0);
    step(2'b01, 2'b00, rr(0, 0), 1'b0);
    step(2'b00, 2'b00, rr(0, 0), 1'b0);
    check("t5_drop", 32'({bit_clk[0], fall_tick[0]}), 32'h0);

    // Asynchronous reset mid-run, then default ratio after release.
    repeat (5) step(2'b11, 2'b00, rr(0, 0), 1'b0);
    #2 rst = 1'b1;
    #1 check("t5_async_rst",
             32'({bit_clk, rise_tick, fall_tick, div_err}), 32'h0);
    @(negedge sys_clk);
    rst = 1'b0;
    model_reset();
    hist = '0;
    repeat (16) step(2'b01, 2'b00, rr(0, 0), 1'b0);
    check("t5_def_div", hist[15:0], 32'hFF00);

`ifdef CLKGEN_SYNC_EN
    step(2'b00, 2'b11, rr(6, 9), 1'b0);
    repeat (13) step(2'b11, 2'b00, rr(0, 0), 1'b0);
    step(2'b11, 2'b00, rr(0, 0), 1'b1);
    check("t6_sync_rise", 32'(rise_tick), 32'h3);
    repeat (4) step(2'b01, 2'b00, rr(0, 0), 1'b0);
    step(2'b01, 2'b00, rr(0, 0), 1'b1);
    check("t6_idle_quiet", 32'({bit_clk[1], rise_tick[1]}), 32'h0);
`endif

    // Random traffic against the model.
    begin
      logic [NCH-1:0]       en;
      logic [NCH-1:0]       ld;
      logic [NCH*DIV_W-1:0] rat;
      logic                 sy;
      en = '0;
      for (int n = 0; n < 4000; n++) begin
        ld  = '0;
        rat = '0;
        sy  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
          if ($urandom_range(0, 9) == 0) begin
            ld[c] = 1'b1;
            rat[c*DIV_W +: DIV_W] = 16'($urandom_range(0, 13));
          end
        end
`ifdef CLKGEN_SYNC_EN
        sy = ($urandom_range(0, 39) == 0);
`endif
        step(en, ld, rat, sy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
